codificador_hamming_tx: RTL and testbench

SECDED Hamming(8,4) encoder: the transmit end of the link whose receive end is the `Correccion_de_error` corrector. Accepts a 4-bit data nibble over a valid/ready handshake, builds the 8-bit codeword in the exact bit layout the corrector decodes, and holds it in a registered output stage until the downstream accepts it. An optional error-injection path flips codeword bits on demand so the decoder chain can be exercised in-system.

---
 rtl/codificador_hamming_tx.sv | 108 ++++++++++
 tb/tb_codificador_hamming_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/codificador_hamming_tx.sv
// SECDED Hamming(8,4) transmit encoder with a single-entry registered output stage.
// Define HAMMING_TX_INYECCION_EN to build the one-shot codeword error-injection path.
module codificador_hamming_tx (
  input  logic       reloj,
  input  logic       reset,
  input  logic [3:0] dato,
  input  logic       valido_entrada,
  output logic       listo_entrada,
  output logic [7:0] palabra,
  output logic       valido_salida,
  input  logic       listo_salida,
  input  logic [7:0] mascara_error,
  input  logic       inyectar,
  output logic       inyeccion_armada,
  output logic [7:0] contador_palabras
);

  typedef enum logic {VACIO = 1'b0, LLENO = 1'b1} estado_t;

  estado_t    estado_q, estado_d;
  logic [7:0] palabra_q, palabra_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] codificada;
  logic [7:0] mascara_ef;
  logic       xfer_in, xfer_out;

  // palabra[i] carries Hamming position i+1; bit 7 is overall even parity.
  always_comb begin
    codificada    = 8'h00;
    codificada[2] = dato[0];
    codificada[4] = dato[1];
    codificada[5] = dato[2];
    codificada[6] = dato[3];
    codificada[0] = dato[0] ^ dato[1] ^ dato[3];
    codificada[1] = dato[0] ^ dato[2] ^ dato[3];
    codificada[3] = dato[1] ^ dato[2] ^ dato[3];
    codificada[7] = ^codificada[6:0];
  end

  assign valido_salida     = (estado_q == LLENO);
  assign listo_entrada     = reset || !valido_salida || listo_salida;
  assign xfer_in           = !reset && valido_entrada && listo_entrada;
  assign xfer_out          = valido_salida && listo_salida;
  assign palabra           = palabra_q;
  assign contador_palabras = cnt_q;

`ifdef HAMMING_TX_INYECCION_EN
  logic [7:0] mascara_q, mascara_d;
  logic       armada_q, armada_d;

  // A pulse coinciding with a transfer in hits that same word and never arms.
  assign mascara_ef = inyectar ? mascara_error : (armada_q ? mascara_q : 8'h00);

  always_comb begin
    mascara_d = mascara_q;
    armada_d  = armada_q;
    if (xfer_in) begin
      armada_d = 1'b0;
    end else if (inyectar) begin
      armada_d  = 1'b1;
      mascara_d = mascara_error;
    end
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      mascara_q <= 8'h00;
      armada_q  <= 1'b0;
    end else begin
      mascara_q <= mascara_d;
      armada_q  <= armada_d;
    end
  end

  assign inyeccion_armada = armada_q;
`else
  logic unused_iny;
  assign unused_iny       = ^{mascara_error, inyectar};
  assign mascara_ef       = 8'h00;
  assign inyeccion_armada = 1'b0;
`endif

  always_comb begin
    estado_d  = estado_q;
    palabra_d = palabra_q;
    cnt_d     = cnt_q;
    if (xfer_out) cnt_d = cnt_q + 8'd1;
    unique case (estado_q)
      VACIO: if (xfer_in) estado_d = LLENO;
      LLENO: if (xfer_out && !xfer_in) estado_d = VACIO;
      default: estado_d = VACIO;
    endcase
    if (xfer_in) palabra_d = codificada ^ mascara_ef;
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q  <= VACIO;
      palabra_q <= 8'h00;
      cnt_q     <= 8'h00;
    end else begin
      estado_q  <= estado_d;
      palabra_q <= palabra_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_codificador_hamming_tx.sv
// Directed bench for codificador_hamming_tx with hand-computed codewords.
module tb_codificador_hamming_tx;
  logic       reloj = 1'b0;
  logic       reset, valido_entrada, listo_salida, inyectar;
  logic [3:0] dato;
  logic [7:0] mascara_error;
  logic       listo_entrada, valido_salida, inyeccion_armada;
  logic [7:0] palabra, contador_palabras;

  int n_tot = 0;
  int n_ok  = 0;

  // Hand-encoded codewords for nibbles 0..F.
  logic [7:0] tabla [16] = '{8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
                             8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF};

  codificador_hamming_tx dut (
    .reloj(reloj), .reset(reset), .dato(dato), .valido_entrada(valido_entrada),
    .listo_entrada(listo_entrada), .palabra(palabra), .valido_salida(valido_salida),
    .listo_salida(listo_salida), .mascara_error(mascara_error), .inyectar(inyectar),
    .inyeccion_armada(inyeccion_armada), .contador_palabras(contador_palabras)
  );

  always #5 reloj = ~reloj;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic decode_chk(input logic [3:0] d);
    logic [2:0] s;
    s[0] = palabra[0] ^ palabra[2] ^ palabra[4] ^ palabra[6];
    s[1] = palabra[1] ^ palabra[2] ^ palabra[5] ^ palabra[6];
    s[2] = palabra[3] ^ palabra[4] ^ palabra[5] ^ palabra[6];
    chk("sindrome", {29'd0, s}, 32'd0);
    chk("paridad", {31'd0, ^palabra}, 32'd0);
    chk("dato_rec", {28'd0, palabra[6], palabra[5], palabra[4], palabra[2]}, {28'd0, d});
  endtask

  initial begin
    reset = 1'b1; valido_entrada = 1'b1; dato = 4'hF; listo_salida = 1'b1;
    inyectar = 1'b0; mascara_error = 8'h00;
    #1;
    chk("listo_en_reset", listo_entrada, 1);
    tick(); tick();
    chk("listo_en_reset2", listo_entrada, 1);
    chk("no_acepta_en_reset", valido_salida, 0);
    reset = 1'b0; valido_entrada = 1'b0;
    #1;
    chk("rst_palabra", palabra, 8'h00);
    chk("rst_valido", valido_salida, 0);
    chk("rst_cnt", contador_palabras, 0);
    chk("rst_armada", inyeccion_armada, 0);
    chk("rst_listo", listo_entrada, 1);

    // Four basic words
    valido_entrada = 1'b1;
    dato = 4'h0; tick(); chk("w0", palabra, 8'h00); chk("w0_v", valido_salida, 1);
    dato = 4'h1; tick(); chk("w1", palabra, 8'h87);
    dato = 4'hB; tick(); chk("wB", palabra, 8'h55);
    dato = 4'hF; tick(); chk("wF", palabra, 8'hFF);
    valido_entrada = 1'b0; tick();
    chk("cnt4", contador_palabras, 4);
    chk("vacio", valido_salida, 0);

    // Exhaustive via reference decoder
    valido_entrada = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dato = 4'(i); tick();
      decode_chk(4'(i));
      chk("tabla", palabra, tabla[i]);
    end
    valido_entrada = 1'b0; tick();
    chk("cnt20", contador_palabras, 20);

    // Backpressure
    listo_salida = 1'b0; valido_entrada = 1'b1; dato = 4'hB; tick();
    chk("bp_palabra0", palabra, 8'h55);
    for (int i = 0; i < 5; i++) begin
      dato = 4'(i + 2); #1;
      chk("bp_listo", listo_entrada, 0);
      tick();
      chk("bp_palabra", palabra, 8'h55);
      chk("bp_valido", valido_salida, 1);
      chk("bp_cnt", contador_palabras, 20);
    end
    listo_salida = 1'b1; dato = 4'h3; #1;
    chk("bp_listo_lib", listo_entrada, 1);
    tick();
    chk("bp_sig", palabra, 8'h1E);
    chk("bp_cnt21", contador_palabras, 21);
    valido_entrada = 1'b0; tick();
    chk("bp_cnt22", contador_palabras, 22);

    // 256-word stream with counter wrap
    reset = 1'b1; tick(); reset = 1'b0;
    valido_entrada = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dato = 4'(i); tick();
      chk("str_palabra", palabra, tabla[i % 16]);
      chk("str_valido", valido_salida, 1);
    end
    chk("str_cnt255", contador_palabras, 255);
    valido_entrada = 1'b0; tick();
    chk("str_wrap", contador_palabras, 0);

    // Injection
    inyectar = 1'b1; mascara_error = 8'h08; tick();
    inyectar = 1'b0; mascara_error = 8'hFF;
`ifdef HAMMING_TX_INYECCION_EN
    chk("iny_armada", inyeccion_armada, 1);
    valido_entrada = 1'b1; dato = 4'hB; tick();
    chk("iny_simple", palabra, 8'h5D);
    chk("iny_desarmada", inyeccion_armada, 0);
    tick();
    chk("iny_limpia", palabra, 8'h55);
    inyectar = 1'b1; mascara_error = 8'h0C; tick();
    chk("iny_doble", palabra, 8'h59);
    chk("iny_coinc_armada", inyeccion_armada, 0);
    inyectar = 1'b0; tick();
    chk("iny_limpia2", palabra, 8'h55);
`else
    chk("iny_off_armada", inyeccion_armada, 0);
    valido_entrada = 1'b1; dato = 4'hB; tick();
    chk("iny_off", palabra, 8'h55);
`endif
    valido_entrada = 1'b0; tick();

    // Reset with held word and armed mask
    listo_salida = 1'b0; valido_entrada = 1'b1; dato = 4'hB; tick();
    valido_entrada = 1'b0; inyectar = 1'b1; mascara_error = 8'h08; tick();
    inyectar = 1'b0;
    chk("rst2_held", palabra, 8'h55);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_valido", valido_salida, 0);
    chk("rst2_palabra", palabra, 8'h00);
    chk("rst2_armada", inyeccion_armada, 0);
    listo_salida = 1'b1; valido_entrada = 1'b1; dato = 4'hB; tick();
    chk("rst2_limpia", palabra, 8'h55);
    valido_entrada = 1'b0; tick();

    $display("%0d/%0d checks passed", n_ok, n_tot);
    $finish;
  end
endmodule
